id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: data 32 bits, register index 5 bits, control 8 bits.
REQ-002 The ports SHALL be:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- id_valid  input  1  decode slot holds a real instruction
- id_pc  input  32  PC of decoding instruction
- id_rA, id_rB  input  5  source register indices
- id_rw  input  5  destination register index
- id_reg_a, id_reg_b  input  32  register-file read data
- id_imm  input  32  extended immediate
- id_ctrl  input  8  ALU/branch control word
- id_we_alu  input  1  instruction writes rw from the ALU
- id_we_mem  input  1  instruction is a load writing rw
- fwd_a_alu, fwd_b_alu  input  1  forward EX result to A/B
- fwd_a_mem, fwd_b_mem  input  1  forward MEM result to A/B
- bubble  input  1  load-use hazard
- exe_result, mem_result  input  32  forwarding sources
- flush  input  1  taken branch/jump resolved in EX
- freeze  input  1  EX stage busy; hold all state
- ex_valid  output  1  EX slot valid
- ex_pc, ex_a, ex_b, ex_imm  output  32  registered operands
- ex_rw  output  5  registered destination index
- ex_ctrl  output  8  registered control word
- ex_we_alu, ex_we_mem  output  1  registered write enables, gated by ex_valid
- upstream_hold  output  1  combinational; IF/ID and PC must not advance
- stall_count  output  16  load-use stall counter (feature-dependent)

Function
REQ-003 Operand A capture value SHALL be exe_result if fwd_a_alu, else mem_result if fwd_a_mem, else id_reg_a; the same rule SHALL apply to B with the fwd_b_* inputs (EX forwarding has priority).
REQ-004 Each rising edge SHALL apply exactly one action in priority order: rst, flush, freeze, bubble, load.
REQ-005 Flush SHALL load a NOP: ex_valid=0, ex_we_alu=0, ex_we_mem=0, ex_rw=0, ex_ctrl=0; data fields may retain old values.
REQ-006 Freeze SHALL hold every registered output unchanged, including ex_valid.
REQ-007 Bubble (without flush/freeze) SHALL load a NOP as in REQ-005.
REQ-008 Load SHALL capture id_pc, forwarded A/B, id_imm, id_rw, id_ctrl; ex_valid=id_valid; ex_we_alu=id_we_alu&id_valid; ex_we_mem=id_we_mem&id_valid.
REQ-009 Latency SHALL be one cycle from decode inputs to ex_* outputs.
REQ-010 upstream_hold SHALL equal (bubble|freeze)&~flush, combinationally.
REQ-011 A captured id_rw of 0 SHALL force ex_we_alu=ex_we_mem=0.
REQ-012 Simultaneous flush and bubble SHALL produce a NOP with upstream_hold=0.

Reset
REQ-013 On rst high at a rising edge, all registered outputs SHALL become 0, including stall_count.
REQ-014 Reset SHALL override flush, freeze and bubble in the same cycle; after rst deasserts, the first load occurs on the next rising edge.

Configuration
REQ-015 With macro ID_EX_STALL_CNT_EN defined, stall_count SHALL increment by 1 on each edge where the bubble action (REQ-007) is taken, saturating at 0xFFFF; without it, stall_count SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-016 Load: id_valid=1, id_reg_a=0x11, fwd_*=0 -> next cycle ex_a=0x11, ex_valid=1.
REQ-017 Forward priority: fwd_a_alu=1, fwd_a_mem=1, exe_result=0xAA, mem_result=0xBB -> ex_a=0xAA; fwd_b_mem only -> ex_b=0xBB.
REQ-018 Bubble: bubble=1, id_we_alu=1 -> upstream_hold=1, next cycle ex_valid=0, ex_we_alu=0; stall_count +1 with ID_EX_STALL_CNT_EN.
REQ-019 Freeze over bubble: freeze=1, bubble=1 for 3 cycles -> all ex_* unchanged, upstream_hold=1, stall_count unchanged.
REQ-020 Flush+bubble: both 1 -> upstream_hold=0, next cycle NOP; rst during freeze -> all outputs 0 next cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, flush/freeze/bubble control.
// Optional load-use stall counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rA,
    input  logic [4:0]  id_rB,
    input  logic [4:0]  id_rw,
    input  logic [31:0] id_reg_a,
    input  logic [31:0] id_reg_b,
    input  logic [31:0] id_imm,
    input  logic [7:0]  id_ctrl,
    input  logic        id_we_alu,
    input  logic        id_we_mem,
    input  logic        fwd_a_alu,
    input  logic        fwd_b_alu,
    input  logic        fwd_a_mem,
    input  logic        fwd_b_mem,
    input  logic        bubble,
    input  logic [31:0] exe_result,
    input  logic [31:0] mem_result,
    input  logic        flush,
    input  logic        freeze,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rw,
    output logic [7:0]  ex_ctrl,
    output logic        ex_we_alu,
    output logic        ex_we_mem,
    output logic        upstream_hold,
    output logic [15:0] stall_count
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [4:0]  r_rw;
    logic [7:0]  r_ctrl;
    logic        r_we_alu;
    logic        r_we_mem;

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_wr_ok;

    // Register indices are decoded upstream for hazard detection only.
    logic        w_unused;
    assign w_unused = ^{id_rA, id_rB};

    // EX result is younger than MEM result, so it wins when both match.
    assign w_a = fwd_a_alu ? exe_result : (fwd_a_mem ? mem_result : id_reg_a);
    assign w_b = fwd_b_alu ? exe_result : (fwd_b_mem ? mem_result : id_reg_b);

    // Writes to r0 are dropped here so later stages never see them.
    assign w_wr_ok = id_valid & (id_rw != 5'd0);

    assign upstream_hold = (bubble | freeze) & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_imm    <= '0;
            r_rw     <= '0;
            r_ctrl   <= '0;
            r_we_alu <= 1'b0;
            r_we_mem <= 1'b0;
        end else if (flush || (!freeze && bubble)) begin
            // NOP insertion; data fields keep stale values.
            r_valid  <= 1'b0;
            r_rw     <= '0;
            r_ctrl   <= '0;
            r_we_alu <= 1'b0;
            r_we_mem <= 1'b0;
        end else if (!freeze) begin
            r_valid  <= id_valid;
            r_pc     <= id_pc;
            r_a      <= w_a;
            r_b      <= w_b;
            r_imm    <= id_imm;
            r_rw     <= id_rw;
            r_ctrl   <= id_ctrl;
            r_we_alu <= id_we_alu & w_wr_ok;
            r_we_mem <= id_we_mem & w_wr_ok;
        end
    end

    assign ex_valid  = r_valid;
    assign ex_pc     = r_pc;
    assign ex_a      = r_a;
    assign ex_b      = r_b;
    assign ex_imm    = r_imm;
    assign ex_rw     = r_rw;
    assign ex_ctrl   = r_ctrl;
    assign ex_we_alu = r_we_alu;
    assign ex_we_mem = r_we_mem;

`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    logic        w_bubble_take;

    assign w_bubble_take = bubble & ~flush & ~freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_bubble_take && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_count = r_stall_cnt;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver queues hand-computed expectations,
// monitor pops one per rising edge and compares.
module tb_id_ex_stage;

`ifdef ID_EX_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rA, id_rB, id_rw;
    logic [31:0] id_reg_a, id_reg_b, id_imm;
    logic [7:0]  id_ctrl;
    logic        id_we_alu, id_we_mem;
    logic        fwd_a_alu, fwd_b_alu, fwd_a_mem, fwd_b_mem;
    logic        bubble, flush, freeze;
    logic [31:0] exe_result, mem_result;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
    logic [4:0]  ex_rw;
    logic [7:0]  ex_ctrl;
    logic        ex_we_alu, ex_we_mem;
    logic        upstream_hold;
    logic [15:0] stall_count;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rw;
        logic [7:0]  ctrl;
        logic        wa;
        logic        wm;
        logic [15:0] cnt;
    } out_t;

    typedef struct packed {
        logic chk_data;
        out_t o;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rA(id_rA), .id_rB(id_rB), .id_rw(id_rw),
        .id_reg_a(id_reg_a), .id_reg_b(id_reg_b), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_we_alu(id_we_alu), .id_we_mem(id_we_mem),
        .fwd_a_alu(fwd_a_alu), .fwd_b_alu(fwd_b_alu),
        .fwd_a_mem(fwd_a_mem), .fwd_b_mem(fwd_b_mem),
        .bubble(bubble), .exe_result(exe_result), .mem_result(mem_result),
        .flush(flush), .freeze(freeze),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
        .ex_imm(ex_imm), .ex_rw(ex_rw), .ex_ctrl(ex_ctrl),
        .ex_we_alu(ex_we_alu), .ex_we_mem(ex_we_mem),
        .upstream_hold(upstream_hold), .stall_count(stall_count)
    );

    function automatic logic [15:0] cnt(input int n);
        return CNT_EN ? 16'(n) : 16'd0;
    endfunction

    function automatic exp_t ld(input logic v, input logic [31:0] pc, a, b, imm,
                                input logic [4:0] rw, input logic [7:0] ctrl,
                                input logic wa, wm, input logic [15:0] c);
        exp_t e;
        e.chk_data = 1'b1;
        e.o = '{v, pc, a, b, imm, rw, ctrl, wa, wm, c};
        return e;
    endfunction

    function automatic exp_t nop(input logic [15:0] c);
        exp_t e;
        e.chk_data = 1'b0;
        e.o = '{1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 8'd0, 1'b0, 1'b0, c};
        return e;
    endfunction

    task automatic idle();
        rst = 0; id_valid = 0; id_pc = 0; id_rA = 0; id_rB = 0; id_rw = 0;
        id_reg_a = 0; id_reg_b = 0; id_imm = 0; id_ctrl = 0;
        id_we_alu = 0; id_we_mem = 0;
        fwd_a_alu = 0; fwd_b_alu = 0; fwd_a_mem = 0; fwd_b_mem = 0;
        bubble = 0; flush = 0; freeze = 0; exe_result = 0; mem_result = 0;
    endtask

    // Called at a falling edge with inputs already set; queues the
    // expectation for the coming rising edge.
    task automatic cyc(input exp_t e, input logic hold, input string name);
        #1;
        n_checks++;
        if (upstream_hold !== hold) begin
            n_fail++;
            $display("FAIL hold_%s: got %b expected %b", name, upstream_hold, hold);
        end
        sb.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        out_t act;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            act = '{ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_rw, ex_ctrl,
                    ex_we_alu, ex_we_mem, stall_count};
            n_checks++;
            if (e.chk_data ? (act !== e.o)
                           : ({act.valid, act.rw, act.ctrl, act.wa, act.wm, act.cnt} !==
                              {e.o.valid, e.o.rw, e.o.ctrl, e.o.wa, e.o.wm, e.o.cnt})) begin
                n_fail++;
                $display("FAIL out @%0t: got %h expected %h (data checked=%b)",
                         $time, act, e.o, e.chk_data);
            end
        end
    end

    initial begin
        idle();
        @(negedge clk);
        // reset overrides flush/freeze/bubble
        rst = 1; flush = 1; freeze = 1; bubble = 1; id_valid = 1; id_pc = 32'h55;
        cyc(ld(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0), 1'b0, "rst");

        idle(); id_valid = 1; id_pc = 32'h100; id_reg_a = 32'h11; id_reg_b = 32'h22;
        id_imm = 32'h5; id_rw = 3; id_ctrl = 8'h12; id_we_alu = 1;
        cyc(ld(1, 32'h100, 32'h11, 32'h22, 32'h5, 3, 8'h12, 1, 0, cnt(0)), 1'b0, "load");

        idle(); id_valid = 1; id_pc = 32'h104; id_reg_a = 1; id_reg_b = 2;
        fwd_a_alu = 1; fwd_a_mem = 1; fwd_b_mem = 1;
        exe_result = 32'hAA; mem_result = 32'hBB;
        id_imm = 32'h7; id_rw = 4; id_ctrl = 8'h34; id_we_mem = 1;
        cyc(ld(1, 32'h104, 32'hAA, 32'hBB, 32'h7, 4, 8'h34, 0, 1, cnt(0)), 1'b0, "fwd1");

        idle(); id_valid = 1; id_pc = 32'h108; id_reg_a = 1; id_reg_b = 2;
        fwd_a_mem = 1; fwd_b_alu = 1; exe_result = 32'hAA; mem_result = 32'hBB;
        id_imm = 32'h8; id_rw = 5; id_ctrl = 8'h01; id_we_alu = 1;
        cyc(ld(1, 32'h108, 32'hBB, 32'hAA, 32'h8, 5, 8'h01, 1, 0, cnt(0)), 1'b0, "fwd2");

        idle(); id_valid = 1; id_pc = 32'h200; id_reg_a = 32'h44; id_reg_b = 32'h55;
        id_imm = 32'h66; id_rw = 7; id_ctrl = 8'h77; id_we_alu = 1; id_we_mem = 1;
        cyc(ld(1, 32'h200, 32'h44, 32'h55, 32'h66, 7, 8'h77, 1, 1, cnt(0)), 1'b0, "load2");

        // freeze beats bubble for three cycles; junk on decode inputs
        for (int i = 0; i < 3; i++) begin
            idle(); freeze = 1; bubble = 1; id_pc = 32'hDEAD; id_reg_a = 32'hBEEF;
            id_rw = 9; id_ctrl = 8'hFF; id_we_alu = 1;
            cyc(ld(1, 32'h200, 32'h44, 32'h55, 32'h66, 7, 8'h77, 1, 1, cnt(0)), 1'b1, "frz");
        end

        idle(); bubble = 1; id_valid = 1; id_we_alu = 1; id_rw = 9; id_ctrl = 8'h3C;
        cyc(nop(cnt(1)), 1'b1, "bub1");
        idle(); bubble = 1; id_valid = 1; id_we_mem = 1; id_rw = 10;
        cyc(nop(cnt(2)), 1'b1, "bub2");

        idle(); flush = 1; bubble = 1; id_valid = 1; id_we_alu = 1; id_rw = 9;
        cyc(nop(cnt(2)), 1'b0, "flush_bub");

        idle(); id_valid = 1; id_pc = 32'h300; id_reg_a = 1; id_reg_b = 2; id_imm = 3;
        id_rw = 0; id_ctrl = 8'h0F; id_we_alu = 1; id_we_mem = 1;
        cyc(ld(1, 32'h300, 1, 2, 3, 0, 8'h0F, 0, 0, cnt(2)), 1'b0, "rw0");

        idle(); id_valid = 0; id_pc = 32'h304; id_reg_a = 32'hA; id_reg_b = 32'hB;
        id_imm = 32'hC; id_rw = 8; id_ctrl = 8'hF0; id_we_alu = 1;
        cyc(ld(0, 32'h304, 32'hA, 32'hB, 32'hC, 8, 8'hF0, 0, 0, cnt(2)), 1'b0, "inval");

        idle(); flush = 1; freeze = 1; id_valid = 1; id_rw = 3; id_we_alu = 1;
        cyc(nop(cnt(2)), 1'b0, "flush_frz");

        idle(); id_valid = 1; id_pc = 32'h400; id_reg_a = 32'h99; id_rw = 1;
        id_ctrl = 8'h02; id_we_alu = 1;
        cyc(ld(1, 32'h400, 32'h99, 0, 0, 1, 8'h02, 1, 0, cnt(2)), 1'b0, "load3");

        idle(); rst = 1; freeze = 1;
        cyc(ld(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0), 1'b1, "rst_frz");

        idle(); id_valid = 1; id_pc = 32'h500; id_reg_a = 32'h11; id_rw = 2;
        id_we_alu = 1;
        cyc(ld(1, 32'h500, 32'h11, 0, 0, 2, 8'h00, 1, 0, 16'd0), 1'b0, "post_rst");

        idle(); freeze = 1; id_pc = 32'h777;
        cyc(ld(1, 32'h500, 32'h11, 0, 0, 2, 8'h00, 1, 0, 16'd0), 1'b1, "frz2");

        idle();
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
